// File: rtl/piso_lsb2msb.sv
`default_nettype none
// ============================================================================
//  Module      : piso_lsb2msb
//  Description : Parallel-in, serial-out shift register. The register shifts
//                from LSB toward MSB, the serial output is taken at the MSB
//                (words leave MSB-first) and a fill bit enters at the LSB.
//                A valid/ready load handshake, a bit counter and a two-state
//                FSM frame each word. Back-to-back words leave with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_lsb2msb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             si,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter value of the final (LSB) bit of a frame
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    logic             w_last;
    logic             w_shifting;

    // Output decode: everything comes from registers except load_ready,
    // which also depends on shift_en so a new word can enter with no bubble.
    assign w_last     = (state_q == ST_SHIFT) && (cnt_q == C_LAST_CNT);
    assign busy       = (state_q == ST_SHIFT);
    assign so_valid   = (state_q == ST_SHIFT);
    assign so_last    = w_last;
    assign so         = shreg_q[WIDTH-1];
    assign q          = shreg_q;
    assign load_ready = (state_q == ST_IDLE) || (w_last && shift_en);
    assign w_shifting = (state_q == ST_SHIFT) && shift_en;

    // Next-state, counter and shift-register update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    shreg_d = load_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_shifting) begin
                    if (!w_last) begin
                        shreg_d = {shreg_q[WIDTH-2:0], si};
                        cnt_d   = cnt_q + C_CNT_ONE;
                    end else if (load_valid) begin
                        // Back-to-back word: fill bit is not used on this edge
                        shreg_d = load_data;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = {shreg_q[WIDTH-2:0], si};
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and shift-register flops; reset aborts any frame at once
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_lsb2msb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_lsb2msb
//  Description : Self-checking bench for piso_lsb2msb (WIDTH=4). Hand-built
//                vector table for the directed frames, an asynchronous
//                mid-frame reset sequence, and a randomized run against a
//                word-level reference model with a serial-bit scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_lsb2msb;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             clear_n = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             shift_en = 1'b0;
    logic             si = 1'b0;
    logic             load_ready;
    logic             so;
    logic             so_valid;
    logic             so_last;
    logic [WIDTH-1:0] q;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    piso_lsb2msb #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .si         (si),
        .so         (so),
        .so_valid   (so_valid),
        .so_last    (so_last),
        .q          (q),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // {so, so_valid, so_last, load_ready, busy, q[3:0]}
    typedef struct {
        logic       lv;
        logic [3:0] ld;
        logic       se;
        logic       si;
        logic [8:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic lv, input logic [3:0] ld, input logic se,
                       input logic fill, input logic e_so, input logic e_v,
                       input logic e_l, input logic e_r, input logic e_b,
                       input logic [3:0] e_q);
        vec_t v;
        v.lv  = lv;
        v.ld  = ld;
        v.se  = se;
        v.si  = fill;
        v.exp = {e_so, e_v, e_l, e_r, e_b, e_q};
        vq.push_back(v);
    endtask

    function automatic logic [8:0] outs();
        return {so, so_valid, so_last, load_ready, busy, q};
    endfunction

    task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {so,vld,last,rdy,busy,q}=%b required %b", name, act, exp);
        end
    endtask

    // Word-level reference model
    logic [3:0] m_q;
    bit         m_active;
    int         m_pos;
    logic       sb[$];

    initial begin
        logic [8:0] e;
        bit         m_last, m_rdy, acc;
        logic       exp_bit;

        // ---- Reset held with random inputs ----
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_valid = 1'($urandom);
            load_data  = 4'($urandom);
            shift_en   = 1'($urandom);
            si         = 1'($urandom);
            #1;
            check9("reset_hold", outs(), 9'b0_0_0_1_0_0000);
        end
        @(negedge clk);
        load_valid = 1'b0; shift_en = 1'b0; si = 1'b0; load_data = '0;
        clear_n = 1'b1;

        // ---- Directed vector table ----
        // single word 1011, si=0
        add(1,4'b1011,1,0, 0,0,0,1,0,4'b0000);
        add(0,4'b0000,1,0, 1,1,0,0,1,4'b1011);
        add(0,4'b0000,1,0, 0,1,0,0,1,4'b0110);
        add(0,4'b0000,1,0, 1,1,0,0,1,4'b1100);
        add(0,4'b0000,1,0, 1,1,1,1,1,4'b1000);
        add(0,4'b0000,1,0, 0,0,0,1,0,4'b0000);
        // back-to-back 1100 then 0110; second word offered early and held
        add(1,4'b1100,1,0, 0,0,0,1,0,4'b0000);
        add(1,4'b0110,1,0, 1,1,0,0,1,4'b1100);
        add(1,4'b0110,1,0, 1,1,0,0,1,4'b1000);
        add(1,4'b0110,1,0, 0,1,0,0,1,4'b0000);
        add(1,4'b0110,1,0, 0,1,1,1,1,4'b0000);
        add(0,4'b0000,1,0, 0,1,0,0,1,4'b0110);
        add(0,4'b0000,1,0, 1,1,0,0,1,4'b1100);
        add(0,4'b0000,1,0, 1,1,0,0,1,4'b1000);
        add(0,4'b0000,1,0, 0,1,1,1,1,4'b0000);
        add(0,4'b0000,1,0, 0,0,0,1,0,4'b0000);
        // stall: 1001, three stall cycles after the second bit, then stall on last bit
        add(1,4'b1001,1,0, 0,0,0,1,0,4'b0000);
        add(0,4'b0000,1,0, 1,1,0,0,1,4'b1001);
        add(0,4'b0000,1,0, 0,1,0,0,1,4'b0010);
        add(0,4'b0000,0,1, 0,1,0,0,1,4'b0100);
        add(0,4'b0000,0,1, 0,1,0,0,1,4'b0100);
        add(0,4'b0000,0,1, 0,1,0,0,1,4'b0100);
        add(0,4'b0000,1,0, 0,1,0,0,1,4'b0100);
        add(1,4'b1111,0,1, 1,1,1,0,1,4'b1000);
        add(1,4'b1111,0,1, 1,1,1,0,1,4'b1000);
        add(0,4'b0000,1,0, 1,1,1,1,1,4'b1000);
        // fill: 0000 with si=1
        add(1,4'b0000,1,1, 0,0,0,1,0,4'b0000);
        add(0,4'b0000,1,1, 0,1,0,0,1,4'b0000);
        add(0,4'b0000,1,1, 0,1,0,0,1,4'b0001);
        add(0,4'b0000,1,1, 0,1,0,0,1,4'b0011);
        add(0,4'b0000,1,1, 0,1,1,1,1,4'b0111);
        add(0,4'b0000,1,1, 1,0,0,1,0,4'b1111);
        // ignored load: 1111 pulsed during cycle 2 of a 0101 frame
        add(1,4'b0101,1,0, 1,0,0,1,0,4'b1111);
        add(0,4'b0000,1,0, 0,1,0,0,1,4'b0101);
        add(1,4'b1111,1,0, 1,1,0,0,1,4'b1010);
        add(0,4'b0000,1,0, 0,1,0,0,1,4'b0100);
        add(0,4'b0000,1,0, 1,1,1,1,1,4'b1000);
        add(0,4'b0000,1,0, 0,0,0,1,0,4'b0000);

        foreach (vq[i]) begin
            @(negedge clk);
            load_valid = vq[i].lv;
            load_data  = vq[i].ld;
            shift_en   = vq[i].se;
            si         = vq[i].si;
            #1;
            check9($sformatf("vec[%0d]", i), outs(), vq[i].exp);
        end

        // ---- Asynchronous reset mid-frame ----
        @(negedge clk);
        load_valid = 1'b1; load_data = 4'b1010; shift_en = 1'b1; si = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        check9("pre_async", outs(), 9'b1_1_0_0_1_1010);
        @(posedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        check9("async_clear", outs(), 9'b0_0_0_1_0_0000);
        @(negedge clk);
        load_valid = 1'b1; load_data = 4'b1111;
        #1;
        check9("async_hold", outs(), 9'b0_0_0_1_0_0000);
        @(negedge clk);
        load_valid = 1'b0; shift_en = 1'b0; si = 1'b0;
        clear_n = 1'b1;
        #1;
        check9("post_release", outs(), 9'b0_0_0_1_0_0000);

        // ---- Randomized run against the reference model ----
        m_q = '0; m_active = 0; m_pos = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            load_valid = 1'($urandom);
            load_data  = 4'($urandom);
            shift_en   = ($urandom_range(3) != 0);
            si         = 1'($urandom);
            #1;
            m_last = m_active && (m_pos == WIDTH - 1);
            m_rdy  = !m_active || (m_last && shift_en);
            e = {m_q[WIDTH-1], m_active, m_last, m_rdy, m_active, m_q};
            check9($sformatf("rand[%0d]", n), outs(), e);

            // scoreboard: each consumed serial bit must be the next queued word bit
            if (m_active && shift_en) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty[%0d]: got so=%b required no bit", n, so);
                end else begin
                    exp_bit = sb.pop_front();
                    checks++;
                    if (so !== exp_bit) begin
                        failures++;
                        $display("FAIL sb_bit[%0d]: got so=%b required %b", n, so, exp_bit);
                    end
                end
            end
            acc = load_valid && m_rdy;
            if (acc)
                for (int b = WIDTH - 1; b >= 0; b--) sb.push_back(load_data[b]);

            // advance the model across the coming edge
            if (acc) begin
                m_q = load_data; m_pos = 0; m_active = 1;
            end else if (m_active && shift_en) begin
                m_q = {m_q[WIDTH-2:0], si};
                if (m_pos == WIDTH - 1) begin
                    m_pos = 0; m_active = 0;
                end else begin
                    m_pos++;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_lsb2msb.md
Name: piso_lsb2msb

Overview:
- Parallel-in, serial-out shift register that shifts from LSB toward MSB. The serial output is taken at the MSB, so words leave MSB-first, and a fill bit enters at the LSB.
- It is the transmit-side counterpart of the team's LSB-to-MSB-ordered serial receivers: a word accepted here arrives at the receiver's q in its original order.
- A valid/ready load handshake, a bit counter and a small FSM frame each word, and back-to-back words are supported with no idle gap.

Parameters:
- WIDTH, 4, word length in bits (≥2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- clear_n  input  1  asynchronous active-low reset.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to serialize.
- shift_en  input  1  allow shifting; 0 stalls the shift in place.
- si  input  1  fill bit shifted into q[0] on each shift.
- so  output  1  serial out; always equals q[WIDTH-1].
- so_valid  output  1  so carries a frame bit this cycle.
- so_last  output  1  so carries the final (LSB) bit of the frame.
- q  output  WIDTH  shift register contents.
- busy  output  1  FSM is in SHIFT.

Behaviour:
- Reset (clear_n low, asynchronous):
  - q=0, bit counter cnt=0, state=IDLE.
  - So so=0, so_valid=0, so_last=0, busy=0, load_ready=1.
  - All of these hold until the first rising clk edge after clear_n rises.
  - Reset mid-frame aborts the frame immediately; the remaining bits are discarded.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - load_ready=1; q holds its value; si and shift_en are ignored.
  - On a clock edge with load_valid=1: q<=load_data, cnt<=0, go to SHIFT.
- SHIFT:
  - busy=1, so_valid=1.
  - so_last = (cnt==WIDTH-1).
  - load_ready = so_last & shift_en.
- Edge in SHIFT with shift_en=0: q, cnt and state hold. so, so_valid and so_last stay stable for as long as the stall lasts.
- Edge in SHIFT with shift_en=1 and cnt<WIDTH-1: q<={q[WIDTH-2:0],si}, cnt<=cnt+1.
- Edge in SHIFT with shift_en=1 and cnt==WIDTH-1 (last bit consumed):
  - If load_valid=1: q<=load_data, cnt<=0, stay in SHIFT. This is the back-to-back case with zero bubble; si is not used on this edge.
  - Else: q<={q[WIDTH-2:0],si}, cnt<=0, go to IDLE.
- Latency: in the k-th unstalled SHIFT cycle after the accept edge (k=0..WIDTH-1), so=load_data[WIDTH-1-k]. The first bit appears in the cycle right after the accept edge.
- Handshake rules:
  - A transfer occurs only on an edge where load_valid & load_ready.
  - load_data is sampled only on that edge.
  - load_valid high while load_ready=0 is ignored, with no side effects.
- After a frame completes unreloaded, q holds WIDTH fill bits (from si), and so = the first si bit shifted in.
- All outputs are driven from registers or from state/cnt decode; there is no combinational path from input to output except load_ready←shift_en and load_ready←state.

Test Plan:
- Reset: hold clear_n=0 with random inputs → q=0000, so_valid=0, busy=0, load_ready=1. Assert clear_n low asynchronously mid-frame → all outputs clear before the next edge.
- Single word, WIDTH=4, load_data=1011, si=0, shift_en=1 → so_valid for 4 cycles; so=1,0,1,1; so_last on the 4th cycle only; then IDLE with q=0000.
- Back-to-back: 1100 then 0110, with load_valid held during the last bit → so=1,1,0,0,0,1,1,0 on 8 consecutive so_valid cycles; load_ready pulses in cycle 4; no gap between words.
- Stall: load 1001, drop shift_en for 3 cycles after the second bit → so holds 0 with so_valid=1 for those cycles; sequence resumes 0,1; load_ready=0 during the stall, even when the stall hits the last bit.
- Fill: load 0000 with si=1 throughout → so=0,0,0,0; final q=1111 in IDLE; so=1 with so_valid=0.
- Ignored load: pulse load_valid with 1111 during cycle 2 of a frame → the current frame is unaffected and the 1111 word is never transmitted.
